// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared op encodings, FSM state type and default widths for
//                the branch PC update stage.
//  Revision    : 1.0  initial release
// ============================================================================
package branch_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_OFF_W = 19;
    localparam int STAT_W        = 16;

    typedef enum logic [1:0] {
        OP_SEQ = 2'b00,
        OP_BR  = 2'b01,
        OP_JR  = 2'b10,
        OP_JAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_COND_LATCH  = 2'd1,
        ST_COND_DECIDE = 2'd2,
        ST_COMMIT      = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pc_unit_if
//  Description : Start/done handshake and PC/link results between the
//                datapath control unit (master) and branch_pc_unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_pc_unit_if #(
    parameter int WIDTH = 32,
    parameter int OFF_W = 19
);
    logic             start;
    logic [1:0]       op;
    logic [OFF_W-1:0] c_offset;
    logic [WIDTH-1:0] rb_value;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] link_value;
    logic             link_we;
    logic             busy;
    logic             done;

    modport master (
        output start, op, c_offset, rb_value,
        input  pc, link_value, link_we, busy, done
    );

    modport slave (
        input  start, op, c_offset, rb_value,
        output pc, link_value, link_we, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/branch_stats.sv
`default_nettype none
// ============================================================================
//  Module      : branch_stats
//  Description : Saturating taken / not-taken counters for committed branches.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_stats
    import branch_pkg::*;
#(
    parameter int CNT_W = STAT_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc_taken,
    input  logic             inc_not_taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] taken_cnt_q,     taken_cnt_d;
    logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;

    always_comb begin
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (inc_taken && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end
        if (inc_not_taken && (not_taken_cnt_q != CNT_MAX)) begin
            not_taken_cnt_d = not_taken_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else begin
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;

endmodule
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pc_unit
//  Description : PC update stage: sequential, conditional PC-relative branch,
//                jump-register and jump-and-link. Optional branch statistics
//                counters are enabled with the BRANCH_STATS_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter int               OFF_W    = DEFAULT_OFF_W,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 clr_n,
    output logic                 con_en,
    input  logic                 con_in,
    branch_pc_unit_if.slave      bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]    taken_cnt,
    output logic [STAT_W-1:0]    not_taken_cnt
`endif
);

    localparam logic [WIDTH-1:0] PC_INC = WIDTH'(1);

    state_e           state_q,      state_d;
    op_e              op_q,         op_d;
    logic [WIDTH-1:0] off_q,        off_d;
    logic [WIDTH-1:0] rb_q,         rb_d;
    logic             taken_q,      taken_d;
    logic [WIDTH-1:0] pc_q,         pc_d;
    logic [WIDTH-1:0] link_value_q, link_value_d;
    logic             link_we_q,    link_we_d;
    logic             con_en_q,     con_en_d;
    logic             done_q,       done_d;

    logic [WIDTH-1:0] sext_offset;
    logic [WIDTH-1:0] pc_seq;

    assign sext_offset = {{(WIDTH-OFF_W){bus.c_offset[OFF_W-1]}}, bus.c_offset};
    assign pc_seq      = pc_q + PC_INC;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rb_d         = rb_q;
        taken_d      = taken_q;
        pc_d         = pc_q;
        link_value_d = link_value_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    off_d   = sext_offset;
                    rb_d    = bus.rb_value;
                    taken_d = 1'b0;
                    state_d = (op_e'(bus.op) == OP_BR) ? ST_COND_LATCH : ST_COMMIT;
                end
            end
            ST_COND_LATCH: begin
                state_d = ST_COND_DECIDE;
            end
            ST_COND_DECIDE: begin
                taken_d = con_in;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                case (op_q)
                    OP_SEQ:  pc_d = pc_seq;
                    OP_BR:   pc_d = taken_q ? (pc_seq + off_q) : pc_seq;
                    OP_JR:   pc_d = rb_q;
                    OP_JAL:  pc_d = rb_q;
                    default: pc_d = pc_seq;
                endcase
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered, so they are decoded from the state being entered.
        con_en_d  = (state_d == ST_COND_LATCH);
        done_d    = (state_d == ST_COMMIT);
        link_we_d = (state_d == ST_COMMIT) && (op_d == OP_JAL);
        if (link_we_d) begin
            link_value_d = pc_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_SEQ;
            off_q        <= '0;
            rb_q         <= '0;
            taken_q      <= 1'b0;
            pc_q         <= RESET_PC;
            link_value_q <= '0;
            link_we_q    <= 1'b0;
            con_en_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rb_q         <= rb_d;
            taken_q      <= taken_d;
            pc_q         <= pc_d;
            link_value_q <= link_value_d;
            link_we_q    <= link_we_d;
            con_en_q     <= con_en_d;
            done_q       <= done_d;
        end
    end

    assign con_en         = con_en_q;
    assign bus.pc         = pc_q;
    assign bus.link_value = link_value_q;
    assign bus.link_we    = link_we_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != ST_IDLE);

`ifdef BRANCH_STATS_EN
    logic br_commit;
    assign br_commit = (state_q == ST_COMMIT) && (op_q == OP_BR);

    branch_stats #(
        .CNT_W (STAT_W)
    ) u_branch_stats (
        .clk           (clk),
        .clr_n         (clr_n),
        .inc_taken     (br_commit && taken_q),
        .inc_not_taken (br_commit && !taken_q),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );
`endif

endmodule
`default_nettype wire
